// File: rtl/comb_bank_sequencer_if.sv
// rtl/comb_bank_sequencer_if.sv - sample/control bundle between the front end and the comb bank sequencer
interface comb_bank_sequencer_if #(
    parameter int NUM_COMBS = 4,
    parameter int LEN_W     = 12
);
    logic                         tick;
    logic                         enable;
    logic [31:0]                  in;
    logic [NUM_COMBS*LEN_W-1:0]   lengths;
    logic [31:0]                  out;
    logic                         out_valid;
    logic                         busy;
    logic                         overrun;

    modport master (
        output tick, enable, in, lengths,
        input  out, out_valid, busy, overrun
    );

    modport slave (
        input  tick, enable, in, lengths,
        output out, out_valid, busy, overrun
    );
endinterface

// File: rtl/comb_bank_sequencer.sv
// rtl/comb_bank_sequencer.sv - time-multiplexed feedback comb bank over one shared delay-line RAM
module comb_bank_sequencer #(
    parameter int NUM_COMBS = 4,
    parameter int SEG_DEPTH = 2048,
    parameter int LEN_W     = $clog2(SEG_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    comb_bank_sequencer_if.slave  bus
);
    localparam int KW    = $clog2(NUM_COMBS);
    localparam int PTR_W = $clog2(SEG_DEPTH);
    localparam int AW    = KW + PTR_W;
    localparam int DEPTH = NUM_COMBS * SEG_DEPTH;
    localparam int ACC_W = 32 + KW;

    localparam logic [2:0] CLEAR = 3'd0;
    localparam logic [2:0] IDLE  = 3'd1;
    localparam logic [2:0] RD    = 3'd2;
    localparam logic [2:0] WT    = 3'd3;
    localparam logic [2:0] WR    = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(SEG_DEPTH);
    localparam logic [AW-1:0]    CLR_LAST = AW'(DEPTH - 1);
    localparam logic [KW-1:0]    K_LAST   = KW'(NUM_COMBS - 1);

    logic [2:0]               state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic [AW-1:0]            clr_q, clr_d;
    logic [PTR_W-1:0]         ptr_q [NUM_COMBS];
    logic [PTR_W-1:0]         ptr_d [NUM_COMBS];
    logic [LEN_W-1:0]         len_q [NUM_COMBS];
    logic [LEN_W-1:0]         len_d [NUM_COMBS];
    logic signed [31:0]       in_q, in_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [31:0]              out_q, out_d;
    logic                     ov_q, ov_d;
    logic                     overrun_q, overrun_d;

    logic [31:0]              mem [DEPTH];
    logic [31:0]              rd_data_q;
    logic signed [31:0]       rd_s;
    logic signed [31:0]       wr_sum;
    logic [AW-1:0]            cur_addr;
    logic [AW-1:0]            waddr;
    logic [31:0]              wdata;
    logic                     we;
    logic [LEN_W-1:0]         ptr_ext;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l == '0)
            return LEN_ONE;
        else if (l > LEN_MAX)
            return LEN_MAX;
        else
            return l;
    endfunction

    // Segments are power-of-two sized, so the comb index simply prefixes the pointer.
    assign cur_addr = {k_q, ptr_q[k_q]};
    assign ptr_ext  = LEN_W'(ptr_q[k_q]);
    assign rd_s     = rd_data_q;
    assign wr_sum   = (in_q >>> 1) + (rd_s >>> 1) + (rd_s >>> 2) + (rd_s >>> 3);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        clr_d     = clr_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        in_d      = in_q;
        acc_d     = acc_q;
        out_d     = out_q;
        ov_d      = 1'b0;
        overrun_d = overrun_q;
        we        = 1'b0;
        waddr     = cur_addr;
        wdata     = wr_sum;

        case (state_q)
            CLEAR: begin
                we    = 1'b1;
                waddr = clr_q;
                wdata = '0;
                clr_d = clr_q + 1'b1;
                if (clr_q == CLR_LAST)
                    state_d = IDLE;
            end
            IDLE: begin
                if (bus.tick) begin
                    if (bus.enable) begin
                        in_d = bus.in;
                        for (int i = 0; i < NUM_COMBS; i++)
                            len_d[i] = clamp_len(bus.lengths[i*LEN_W +: LEN_W]);
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = RD;
                    end else begin
                        out_d = bus.in;
                        ov_d  = 1'b1;
                    end
                end
            end
            RD: state_d = WT;
            WT: state_d = WR;
            WR: begin
                we    = 1'b1;
                acc_d = acc_q + {{KW{rd_s[31]}}, rd_s};
                // A pointer beyond a freshly shrunk length gets one last pass, then wraps.
                if (ptr_ext >= len_q[k_q] - LEN_ONE)
                    ptr_d[k_q] = '0;
                else
                    ptr_d[k_q] = ptr_q[k_q] + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = RD;
                end
            end
            DONE: begin
                out_d   = 32'(acc_q >>> KW);
                ov_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = CLEAR;
        endcase

        if (bus.tick && state_q != CLEAR && state_q != IDLE)
            overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            k_q       <= '0;
            clr_q     <= '0;
            in_q      <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            ov_q      <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_COMBS; i++) begin
                ptr_q[i] <= '0;
                len_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            clr_q     <= clr_d;
            in_q      <= in_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            ov_q      <= ov_d;
            overrun_q <= overrun_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
        end
    end

    // Write-back is suppressed in the reset cycle so an aborted sequence leaves no trace.
    always_ff @(posedge clk) begin
        if (we && !rst)
            mem[waddr] <= wdata;
        rd_data_q <= mem[cur_addr];
    end

    assign bus.out       = out_q;
    assign bus.out_valid = ov_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_comb_bank_sequencer.sv
// tb/tb_comb_bank_sequencer.sv - self-checking bench for comb_bank_sequencer
module tb_comb_bank_sequencer;
    localparam int NC = 4;
    localparam int SD = 16;
    localparam int LW = 5;
    localparam int LAT_EN = 3*NC + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    comb_bank_sequencer_if #(.NUM_COMBS(NC), .LEN_W(LW)) bus ();

    comb_bank_sequencer #(.NUM_COMBS(NC), .SEG_DEPTH(SD), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    int m_mem [NC][SD];
    int m_ptr [NC];

    typedef struct {
        bit               do_rst;
        bit               en;
        logic [31:0]      din;
        logic [NC*LW-1:0] lens;
        logic [31:0]      exp;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NC; k++) begin
            m_ptr[k] = 0;
            for (int a = 0; a < SD; a++) m_mem[k][a] = 0;
        end
    endfunction

    function automatic logic [31:0] model_step(input bit en, input logic [31:0] din,
                                               input logic [NC*LW-1:0] lens);
        longint sum;
        int     len, d, x;
        if (!en) return din;
        sum = 0;
        x   = $signed(din);
        for (int k = 0; k < NC; k++) begin
            len = int'(lens[k*LW +: LW]);
            if (len == 0) len = 1;
            if (len > SD) len = SD;
            d = m_mem[k][m_ptr[k]];
            m_mem[k][m_ptr[k]] = (x >>> 1) + (d >>> 1) + (d >>> 2) + (d >>> 3);
            sum += longint'(d);
            m_ptr[k] = (m_ptr[k] >= len - 1) ? 0 : m_ptr[k] + 1;
        end
        return 32'(sum >>> $clog2(NC));
    endfunction

    task automatic apply_reset();
        int n;
        bit saw_ov;
        @(negedge clk);
        rst = 1'b1;
        bus.tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("rst_out", bus.out, 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_overrun", 32'(bus.overrun), 32'h0);
        n = 0;
        saw_ov = 1'b0;
        while (bus.busy && n < 200) begin
            if (bus.out_valid) saw_ov = 1'b1;
            bus.tick = (n == 10 || n == 40);
            bus.enable = (n == 10);
            @(negedge clk);
            n++;
        end
        bus.tick = 1'b0;
        chk("clear_cycles", 32'(n), 32'(NC*SD));
        chk("clear_no_valid", 32'(saw_ov | bus.out_valid), 32'h0);
        chk("clear_overrun", 32'(bus.overrun), 32'h0);
    endtask

    task automatic do_tick(input bit en, input logic [31:0] din, input logic [NC*LW-1:0] lens,
                           output logic [31:0] got, output int lat, output logic busy1,
                           output logic pulse_end);
        @(negedge clk);
        bus.tick = 1'b1;
        bus.enable = en;
        bus.in = din;
        bus.lengths = lens;
        @(negedge clk);
        bus.tick = 1'b0;
        busy1 = bus.busy;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        got = bus.out;
        @(negedge clk);
        pulse_end = bus.out_valid;
    endtask

    task automatic run_vec(input string name, input bit en, input logic [31:0] din,
                           input logic [NC*LW-1:0] lens, input logic [31:0] exp);
        logic [31:0] got;
        int lat;
        logic busy1, pulse_end;
        do_tick(en, din, lens, got, lat, busy1, pulse_end);
        chk({name, "_out"}, got, exp);
        chk({name, "_lat"}, 32'(lat), en ? 32'(LAT_EN) : 32'd1);
        chk({name, "_busy"}, 32'(busy1), 32'(en));
        chk({name, "_pulse"}, 32'(pulse_end), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [NC*LW-1:0] l4, l1, le, lens;
        logic [31:0] e, din;
        bit en;
        int cnt, first;

        l4 = {5'd4, 5'd4, 5'd4, 5'd4};
        l1 = {5'd1, 5'd1, 5'd1, 5'd1};
        le = {5'd31, 5'd16, 5'd1, 5'd0};

        tbl[0]  = '{0, 1, 32'h40000000, l4, 32'h0};
        tbl[1]  = '{0, 1, 32'h0, l4, 32'h0};
        tbl[2]  = '{0, 1, 32'h0, l4, 32'h0};
        tbl[3]  = '{0, 1, 32'h0, l4, 32'h0};
        tbl[4]  = '{0, 1, 32'h0, l4, 32'h20000000};
        tbl[5]  = '{0, 1, 32'h0, l4, 32'h0};
        tbl[6]  = '{0, 1, 32'h0, l4, 32'h0};
        tbl[7]  = '{0, 1, 32'h0, l4, 32'h0};
        tbl[8]  = '{0, 1, 32'h0, l4, 32'h1C000000};
        tbl[9]  = '{0, 0, 32'hDEADBEEF, l4, 32'hDEADBEEF};
        tbl[10] = '{0, 1, 32'h0, l4, 32'h0};
        tbl[11] = '{0, 1, 32'h0, l4, 32'h0};
        tbl[12] = '{0, 1, 32'h0, l4, 32'h0};
        tbl[13] = '{0, 1, 32'h0, l4, 32'h18800000};
        tbl[14] = '{1, 1, 32'h80000000, l1, 32'h0};
        tbl[15] = '{0, 1, 32'h0, l1, 32'hC0000000};
        tbl[16] = '{0, 1, 32'h0, l1, 32'hC8000000};
        tbl[17] = '{1, 1, 32'h40000000, le, 32'h0};
        tbl[18] = '{0, 1, 32'h0, le, 32'h10000000};

        bus.tick = 1'b0;
        bus.enable = 1'b0;
        bus.in = '0;
        bus.lengths = '0;
        repeat (3) @(negedge clk);
        apply_reset();

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].do_rst) apply_reset();
            e = model_step(tbl[i].en, tbl[i].din, tbl[i].lens);
            run_vec($sformatf("vec%0d", i), tbl[i].en, tbl[i].din, tbl[i].lens, tbl[i].exp);
        end

        // Clamped lengths: let the 16-deep comb echo come round.
        for (int i = 0; i < 18; i++) begin
            e = model_step(1'b1, 32'h0, le);
            run_vec($sformatf("edge%0d", i), 1'b1, 32'h0, le, e);
        end

        // Second tick five cycles after the first must be dropped and flagged.
        apply_reset();
        @(negedge clk);
        bus.tick = 1'b1; bus.enable = 1'b1; bus.in = 32'h40000000; bus.lengths = l4;
        @(negedge clk);
        bus.tick = 1'b0;
        repeat (4) @(negedge clk);
        bus.tick = 1'b1; bus.in = 32'h12345678;
        @(negedge clk);
        bus.tick = 1'b0;
        cnt = 0;
        first = 0;
        for (int c = 6; c <= 40; c++) begin
            if (bus.out_valid) begin
                cnt++;
                if (first == 0) first = c;
            end
            @(negedge clk);
        end
        e = model_step(1'b1, 32'h40000000, l4);
        chk("ovr_valid_count", 32'(cnt), 32'd1);
        chk("ovr_valid_cycle", 32'(first), 32'(LAT_EN));
        chk("ovr_out", bus.out, e);
        chk("ovr_flag", 32'(bus.overrun), 32'd1);
        for (int i = 0; i < 4; i++) begin
            e = model_step(1'b1, 32'h0, l4);
            run_vec($sformatf("ovr_after%0d", i), 1'b1, 32'h0, l4, e);
        end
        chk("ovr_sticky", 32'(bus.overrun), 32'd1);

        // Abort a sequence partway through; clear must restart and nothing may leak.
        @(negedge clk);
        bus.tick = 1'b1; bus.enable = 1'b1; bus.in = 32'h7FFFFFFF; bus.lengths = l1;
        @(negedge clk);
        bus.tick = 1'b0;
        repeat (6) @(negedge clk);
        apply_reset();

        lens = l4;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0)
                for (int k = 0; k < NC; k++) lens[k*LW +: LW] = LW'($urandom_range(0, 31));
            en  = ($urandom_range(0, 7) != 0);
            din = $urandom;
            e = model_step(en, din, lens);
            run_vec($sformatf("rnd%0d", i), en, din, lens, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/comb_bank_sequencer.md
# comb_bank_sequencer

Time-multiplexed scheduler that runs NUM_COMBS feedback comb filters on one shared delay-line RAM, one sample per `tick`. On each accepted tick it walks every comb in turn: reads the delayed sample, writes back the feedback sum, and accumulates the comb outputs. It then presents the averaged result. It sits in the reverb path between the sample-rate front end and the all-pass/output stages, replacing N separate single-comb instances.

## Interface
- NUM_COMBS, 4: number of combs; power of two, 2..8
- SEG_DEPTH, 2048: RAM words reserved per comb; power of two
- LEN_W, $clog2(SEG_DEPTH)+1: width of each delay-length field
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- tick  in  1  one-cycle pulse: new sample on `in`
- enable  in  1  1 = reverb, 0 = bypass
- in  in  32  signed input sample
- lengths  in  NUM_COMBS*LEN_W  delay length per comb; field k = bits [k*LEN_W +: LEN_W]
- out  out  32  signed output sample
- out_valid  out  1  one-cycle pulse when `out` updates
- busy  out  1  sequencer not in IDLE
- overrun  out  1  sticky: a tick arrived while busy (not during CLEAR)

## Operation
- RAM: NUM_COMBS*SEG_DEPTH x 32, inferred block RAM, registered read (1-cycle latency), one read and one write port. Comb k address = k*SEG_DEPTH + ptr[k].
- States: CLEAR, IDLE, RD, WT, WR, DONE.
- CLEAR: entered on reset. Writes 0 to every RAM word, one per cycle, then goes to IDLE. Ticks in CLEAR are dropped without setting overrun.
- IDLE, tick, enable=1: latch `in` and `lengths`, set k=0, clear acc, go to RD.
- IDLE, tick, enable=0: out <= in, pulse out_valid next cycle, stay IDLE. RAM and pointers untouched.
- RD: present addr(k). WT: wait for read data. WR: with d = read data:
  - write mem[addr(k)] <= (in>>>1) + (d>>>1) + (d>>>2) + (d>>>3), 32-bit wrap;
  - acc += d (sign-extended);
  - ptr[k] <= (ptr[k] >= len[k]-1) ? 0 : ptr[k]+1;
  - if k = NUM_COMBS-1 go to DONE, else k++ and go to RD.
- DONE: out <= acc >>> $clog2(NUM_COMBS), arithmetic shift, truncated to 32 bits. Pulse out_valid, go to IDLE.
- acc width: 32+$clog2(NUM_COMBS), signed. No saturation.
- Length clamp at latch: 0 -> 1; values > SEG_DEPTH -> SEG_DEPTH.
- Shrinking length: if ptr >= new len, the current ptr is still read and written once, then ptr wraps to 0.
- Tick while in RD/WT/WR/DONE: ignored, overrun <= 1. overrun clears only on rst.
- enable changes mid-sequence: take effect at the next accepted tick.

## Timing
- Reset values: out=0, out_valid=0, overrun=0, busy=1 (CLEAR), all ptr=0, k=0, acc=0.
- CLEAR lasts NUM_COMBS*SEG_DEPTH cycles; busy falls in the cycle IDLE is entered.
- Enabled path: tick at cycle T; out/out_valid at T+3*NUM_COMBS+2 (NUM_COMBS=4: T+14). busy is high from T+1 through the DONE cycle.
- Bypass path: out/out_valid at T+1; busy stays 0.
- Minimum tick spacing for no overrun: 3*NUM_COMBS+2 cycles.
- rst mid-sequence: abort immediately. Outputs go to reset values, CLEAR restarts, any partial write-back is discarded.
- out holds its value between out_valid pulses.

## Test plan
- Reset/clear (NUM_COMBS=4, SEG_DEPTH=16): assert rst 1 cycle -> busy high exactly 64 cycles, ticks in that window produce no out_valid and overrun=0; RAM reads all 0.
- Impulse (all lengths=4, ticks every 20 cycles): in=0x40000000 on tick 0, then 0 -> out=0 on ticks 0..3, out=0x20000000 on tick 4, out=0x1C000000 on tick 8, 0 on ticks 5..7; out_valid 14 cycles after each tick.
- Bypass: enable=0, in=0xDEADBEEF, tick -> out=0xDEADBEEF, out_valid at T+1, busy=0; next enabled tick shows pointers unchanged.
- Overrun: tick at T and T+5 -> second tick ignored, overrun=1, exactly one out_valid at T+14; overrun stays 1 until rst.
- Length edges: lengths {0,1,16,31} with SEG_DEPTH=16 -> treated as {1,1,16,16}; comb 0 echo on the next tick, comb 2 echo after 16 ticks.
- Negative arithmetic: length 1, in=0x80000000 -> stored value 0xC0000000, next out=0xC0000000 (sign preserved).
